// File: rtl/iob_eth_rx_ctrl_pkg.sv
// Shared types for the Ethernet RX buffer controller: FSM state encoding,
// default counter width and the bank-selection helper.
package iob_eth_rx_ctrl_pkg;

  localparam int unsigned ETH_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ETH_RXC_DISABLED = 2'd0,
    ETH_RXC_RECV     = 2'd1,
    ETH_RXC_DROP     = 2'd2
  } eth_rxc_state_t;

  // Bank to fill next: the other bank when the oldest one holds a frame, else the oldest.
  function automatic logic eth_pick_bank(input logic [1:0] full, input logic oldest);
    return full[oldest] ? ~oldest : oldest;
  endfunction

endpackage

// File: rtl/iob_eth_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module iob_eth_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/iob_eth_rx_ctrl.sv
// Ping-pong receive buffer controller. Define IOB_ETH_RX_CTRL_ERR_CNT_EN to
// build the bad-CRC frame counter; otherwise err_cnt is tied to zero.
module iob_eth_rx_ctrl
  import iob_eth_rx_ctrl_pkg::*;
#(
  parameter int unsigned ETH_BUF_ADDR_W = 11,
  parameter int unsigned ETH_DATA_W     = 8,
  parameter int unsigned CNT_W          = ETH_CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_en,
  input  logic                      cpu_rel,
  input  logic                      rx_wr,
  input  logic [ETH_BUF_ADDR_W-1:0] rx_addr,
  input  logic [ETH_DATA_W-1:0]     rx_data,
  input  logic                      rx_done,
  input  logic                      rx_err,
  output logic                      rx_en,
  output logic                      buf_wr,
  output logic [ETH_BUF_ADDR_W:0]   buf_addr,
  output logic [ETH_DATA_W-1:0]     buf_wdata,
  output logic                      rx_avail,
  output logic                      rx_bank,
  output logic [ETH_BUF_ADDR_W:0]   rx_len,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int unsigned LEN_W = ETH_BUF_ADDR_W + 1;

  eth_rxc_state_t   state_q, state_d;
  logic             fill_q, fill_d;
  logic             oldest_q, oldest_d;
  logic [1:0]       full_q, full_d;
  logic [LEN_W-1:0] len0_q, len0_d, len1_q, len1_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic             in_frame_q, in_frame_d;

  logic             done_c, end_c, rel_c, idle_c, free_c, pick_c, drop_inc_c;
  logic [1:0]       full_rel_c;
  logic             oldest_rel_c;
  logic [LEN_W-1:0] len_new_c;

  assign rx_en     = (state_q != ETH_RXC_DISABLED);
  assign buf_wr    = rx_wr & (state_q == ETH_RXC_RECV);
  assign buf_addr  = {fill_q, rx_addr};
  assign buf_wdata = rx_data;
  assign rx_avail  = |full_q;
  assign rx_bank   = oldest_q;
  assign rx_len    = oldest_q ? len1_q : len0_q;

  // A coincident error overrides a good end-of-frame.
  assign done_c = rx_done & ~rx_err;
  assign end_c  = rx_done | rx_err;
  assign rel_c  = cpu_rel & (|full_q);
  // No frame in progress and none starting this cycle, so a mode change never splits a frame.
  assign idle_c = ~in_frame_q & ~rx_wr;

  always_comb begin
    full_rel_c = full_q;
    if (rel_c) begin
      full_rel_c[oldest_q] = 1'b0;
    end
    oldest_rel_c = oldest_q ^ rel_c;
    free_c       = ~&full_rel_c;
    pick_c       = eth_pick_bank(full_rel_c, oldest_rel_c);
    len_new_c    = (buf_wr && (wcnt_q != '1)) ? wcnt_q + LEN_W'(1) : wcnt_q;
  end

  // Frame tracking: byte count of the frame being written and frame-in-progress flag.
  always_comb begin
    wcnt_d     = end_c ? '0 : len_new_c;
    in_frame_d = in_frame_q;
    if (end_c) begin
      in_frame_d = 1'b0;
    end else if (rx_wr) begin
      in_frame_d = 1'b1;
    end
  end

  // Next-state and bank bookkeeping.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    oldest_d   = oldest_rel_c;
    full_d     = full_rel_c;
    len0_d     = len0_q;
    len1_d     = len1_q;
    drop_inc_c = 1'b0;
    case (state_q)
      ETH_RXC_DISABLED: begin
        if (cpu_en) begin
          if (free_c) begin
            state_d = ETH_RXC_RECV;
            fill_d  = pick_c;
          end else begin
            state_d = ETH_RXC_DROP;
          end
        end
      end
      ETH_RXC_RECV: begin
        if (done_c) begin
          full_d[fill_q] = 1'b1;
          if (fill_q) begin
            len1_d = len_new_c;
          end else begin
            len0_d = len_new_c;
          end
          if (full_rel_c == 2'b00) begin
            oldest_d = fill_q;
          end
          if (!full_rel_c[~fill_q]) begin
            fill_d = ~fill_q;
          end else begin
            state_d = ETH_RXC_DROP;
          end
        end else if (!cpu_en && idle_c) begin
          state_d = ETH_RXC_DISABLED;
        end
      end
      ETH_RXC_DROP: begin
        drop_inc_c = done_c;
        if (idle_c) begin
          if (!cpu_en) begin
            state_d = ETH_RXC_DISABLED;
          end else if (free_c) begin
            state_d = ETH_RXC_RECV;
            fill_d  = pick_c;
          end
        end
      end
      default: state_d = ETH_RXC_DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ETH_RXC_DISABLED;
      fill_q     <= 1'b0;
      oldest_q   <= 1'b0;
      full_q     <= 2'b00;
      len0_q     <= '0;
      len1_q     <= '0;
      wcnt_q     <= '0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      oldest_q   <= oldest_d;
      full_q     <= full_d;
      len0_q     <= len0_d;
      len1_q     <= len1_d;
      wcnt_q     <= wcnt_d;
      in_frame_q <= in_frame_d;
    end
  end

  iob_eth_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (drop_inc_c),
    .cnt (drop_cnt)
  );

`ifdef IOB_ETH_RX_CTRL_ERR_CNT_EN
  logic err_inc_c;
  assign err_inc_c = rx_err & (state_q != ETH_RXC_DISABLED);

  iob_eth_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (err_inc_c),
    .cnt (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_iob_eth_rx_ctrl.sv
// Randomized frame-level bench for iob_eth_rx_ctrl against a queue-based
// model of stored frames (oldest first), drop and error counts.
module tb_iob_eth_rx_ctrl;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst, cpu_en, cpu_rel, rx_wr, rx_done, rx_err;
  logic [AW-1:0] rx_addr;
  logic [DW-1:0] rx_data;
  logic          rx_en, buf_wr, rx_avail, rx_bank;
  logic [AW:0]   buf_addr, rx_len;
  logic [DW-1:0] buf_wdata;
  logic [CW-1:0] drop_cnt, err_cnt;

  iob_eth_rx_ctrl #(.ETH_BUF_ADDR_W(AW), .ETH_DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_rel   (cpu_rel),
    .rx_wr     (rx_wr),
    .rx_addr   (rx_addr),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_en     (rx_en),
    .buf_wr    (buf_wr),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .rx_avail  (rx_avail),
    .rx_bank   (rx_bank),
    .rx_len    (rx_len),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: banks holding good frames in arrival order, the bank the next
  // accepted frame lands in, and expected counters.
  int q_bank[$];
  int q_len[$];
  int fill_m  = 0;
  int drops_m = 0;
  int errs_m  = 0;
  bit en_m    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_release();
    if (q_bank.size() > 0) begin
      if (q_bank.size() == 2) fill_m = q_bank[0];
      void'(q_bank.pop_front());
      void'(q_len.pop_front());
    end
  endtask

  task automatic check_status();
    chk("rx_avail", 32'(rx_avail), 32'(q_bank.size() > 0));
    if (q_bank.size() > 0) begin
      chk("rx_bank", 32'(rx_bank), 32'(q_bank[0]));
      chk("rx_len", 32'(rx_len), 32'(q_len[0]));
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(drops_m));
    chk("err_cnt", 32'(err_cnt), 32'(errs_m));
  endtask

  task automatic do_release();
    cpu_rel = 1'b1;
    model_release();
    next_cycle();
    cpu_rel = 1'b0;
    @(negedge clk);
    check_status();
    next_cycle();
  endtask

  // One frame of len bytes. rel_at: byte index (or len for a separate end
  // cycle) carrying cpu_rel, -1 for none. dis_at: byte index where cpu_en
  // drops, -1 for none.
  task automatic send_frame(input int len, input bit bad, input int rel_at,
                            input bit end_on_last, input int dis_at);
    bit          stored;
    logic [AW:0] ea;
    stored = (q_bank.size() < 2);
    for (int i = 0; i < len; i++) begin
      rx_wr   = 1'b1;
      rx_addr = AW'(i);
      rx_data = DW'($urandom);
      cpu_rel = (i == rel_at);
      if (i == dis_at) begin
        cpu_en = 1'b0;
        en_m   = 1'b0;
      end
      if (end_on_last && (i == len - 1)) begin
        rx_done = bad ? 1'($urandom % 2) : 1'b1;
        rx_err  = bad;
      end
      @(negedge clk);
      chk("buf_wr", 32'(buf_wr), 32'(stored));
      if (stored) begin
        ea = {1'(fill_m), AW'(i)};
        chk("buf_addr", 32'(buf_addr), 32'(ea));
        chk("buf_wdata", 32'(buf_wdata), 32'(rx_data));
      end
      if (cpu_rel) model_release();
      next_cycle();
    end
    rx_wr   = 1'b0;
    cpu_rel = 1'b0;
    if (!end_on_last) begin
      rx_done = bad ? 1'($urandom % 2) : 1'b1;
      rx_err  = bad;
      cpu_rel = (rel_at == len);
      @(negedge clk);
      chk("buf_wr_end", 32'(buf_wr), 32'd0);
      if (cpu_rel) model_release();
      next_cycle();
    end
    rx_done = 1'b0;
    rx_err  = 1'b0;
    cpu_rel = 1'b0;
    if (!bad && stored) begin
      q_bank.push_back(fill_m);
      q_len.push_back(len);
      if (q_bank.size() < 2) fill_m = 1 - fill_m;
    end else if (!bad) begin
      drops_m++;
    end
`ifdef IOB_ETH_RX_CTRL_ERR_CNT_EN
    if (bad) errs_m++;
`endif
    @(negedge clk);
    check_status();
    next_cycle();
    @(negedge clk);
    chk("rx_en", 32'(rx_en), 32'(en_m));
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_rel = 1'b0; rx_wr = 1'b0;
    rx_addr = '0; rx_data = '0; rx_done = 1'b0; rx_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_en", 32'(rx_en), 32'd0);
    chk("rst_buf_wr", 32'(buf_wr), 32'd0);
    chk("rst_buf_addr", 32'(buf_addr), 32'd0);
    chk("rst_rx_len", 32'(rx_len), 32'd0);
    chk("rst_rx_bank", 32'(rx_bank), 32'd0);
    check_status();
    next_cycle();

    cpu_en = 1'b1;
    en_m   = 1'b1;
    next_cycle();
    next_cycle();

    // Fill both banks, drop a third frame while releasing mid-frame,
    // then store a frame whose end coincides with a release.
    send_frame(60, 1'b0, -1, 1'b1, -1);
    send_frame(100, 1'b0, -1, 1'b0, -1);
    send_frame(80, 1'b0, 40, 1'b0, -1);
    send_frame(50, 1'b0, 50, 1'b0, -1);
    do_release();
    send_frame(30, 1'b1, -1, 1'b0, -1);
    send_frame(45, 1'b0, -1, 1'b1, -1);

    for (int f = 0; f < 40; f++) begin
      int len;
      int rel;
      len = int'($urandom_range(1, 120));
      rel = ($urandom % 3 == 0) ? int'($urandom_range(0, len)) : -1;
      if ($urandom % 3 == 0) do_release();
      send_frame(len, ($urandom % 5) == 0, rel, 1'($urandom % 2), -1);
    end

    // Disable mid-frame: frame still completes, then the engine is disarmed.
    send_frame(70, 1'b0, -1, 1'b1, 35);
    do_release();
    do_release();
    do_release();
    chk("dis_rx_en", 32'(rx_en), 32'd0);
    cpu_en = 1'b1;
    en_m   = 1'b1;
    next_cycle();
    next_cycle();
    send_frame(64, 1'b0, -1, 1'b1, -1);
    send_frame(20, 1'b0, -1, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
